// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bundle: ID/EXE/MEM/WB register-file info in,
// stall/flush/forward controls and performance counters out.
//   master : pipeline side (drives hazard inputs, consumes controls)
//   slave  : hazard controller
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned REG_W = 5;

  logic [REG_W-1:0] rs_d;
  logic [REG_W-1:0] rt_d;
  logic             uses_rt_d;
  logic             memtoreg_e;
  logic [REG_W-1:0] writereg_e;
  logic             regwrite_m;
  logic [REG_W-1:0] writereg_m;
  logic             regwrite_w;
  logic [REG_W-1:0] writereg_w;
  logic             redirect_m;

  logic             stall_f;
  logic             stall_d;
  logic             flush_d;
  logic             flush_e;
  logic             flush_m;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output rs_d, rt_d, uses_rt_d, memtoreg_e, writereg_e,
           regwrite_m, writereg_m, regwrite_w, writereg_w, redirect_m,
    input  stall_f, stall_d, flush_d, flush_e, flush_m,
           fwd_a, fwd_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs_d, rt_d, uses_rt_d, memtoreg_e, writereg_e,
           regwrite_m, writereg_m, regwrite_w, writereg_w, redirect_m,
    output stall_f, stall_d, flush_d, flush_e, flush_m,
           fwd_a, fwd_b, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage IF/ID/EXE/MEM/WB pipeline.
// Load-use stall (STALL_CYC cycles), MEM-redirect flushes, EXE operand
// forwarding selects and saturating stall/flush event counters.
// Ports:
//   clk  : rising-edge clock
//   clr  : asynchronous active-low reset
//   hz   : pipe_hazard_ctrl_if slave (hazard inputs, control outputs)
// Stall/flush/forward outputs are combinational in the detect cycle.
module pipe_hazard_ctrl #(
  parameter int unsigned STALL_CYC = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 clr,
  pipe_hazard_ctrl_if.slave    hz
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned SCNT_W = 3;
  localparam logic [SCNT_W-1:0] SCNT_INIT = SCNT_W'(STALL_CYC - 1);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  state_e            state_q, state_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [REG_W-1:0]  rs_e_q, rs_e_d;
  logic [REG_W-1:0]  rt_e_q, rt_e_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic lu_c;
  logic stall_f_c;
  logic stall_d_c;
  logic flush_d_c;
  logic flush_e_c;
  logic flush_m_c;
  logic [1:0] fwd_a_c;
  logic [1:0] fwd_b_c;

  // Load-use: EXE load targets a register the ID instruction reads.
  always_comb begin
    lu_c = hz.memtoreg_e && (hz.writereg_e != '0) &&
           ((hz.writereg_e == hz.rs_d) ||
            (hz.uses_rt_d && (hz.writereg_e == hz.rt_d)));
  end

  // State register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= RUN;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
    end
  end

  // Next state and stall/flush controls; a redirect always wins over a stall.
  always_comb begin
    state_d   = state_q;
    scnt_d    = scnt_q;
    stall_f_c = 1'b0;
    stall_d_c = 1'b0;
    flush_d_c = 1'b0;
    flush_e_c = 1'b0;
    flush_m_c = 1'b0;
    if (hz.redirect_m) begin
      flush_d_c = 1'b1;
      flush_e_c = 1'b1;
      flush_m_c = 1'b1;
      state_d   = RUN;
      scnt_d    = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (lu_c) begin
            stall_f_c = 1'b1;
            stall_d_c = 1'b1;
            flush_e_c = 1'b1;
            if (STALL_CYC > 1) begin
              state_d = STALL;
              scnt_d  = SCNT_INIT;
            end
          end
        end
        STALL: begin
          stall_f_c = 1'b1;
          stall_d_c = 1'b1;
          flush_e_c = 1'b1;
          // scnt holds the stall cycles remaining including this one.
          if (scnt_q <= SCNT_W'(1)) begin
            state_d = RUN;
            scnt_d  = '0;
          end else begin
            scnt_d  = scnt_q - SCNT_W'(1);
          end
        end
        default: begin
          state_d = RUN;
          scnt_d  = '0;
        end
      endcase
    end
  end

  // EXE copies of the source registers; a bubble carries no sources.
  always_comb begin
    rs_e_d = hz.rs_d;
    rt_e_d = hz.uses_rt_d ? hz.rt_d : '0;
    if (flush_e_c) begin
      rs_e_d = '0;
      rt_e_d = '0;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rs_e_q <= '0;
      rt_e_q <= '0;
    end else begin
      rs_e_q <= rs_e_d;
      rt_e_q <= rt_e_d;
    end
  end

  // Forwarding selects: MEM holds the newer value so it beats WB; $0 never forwards.
  always_comb begin
    fwd_a_c = FWD_RF;
    if (hz.regwrite_m && (hz.writereg_m != '0) && (hz.writereg_m == rs_e_q)) begin
      fwd_a_c = FWD_MEM;
    end else if (hz.regwrite_w && (hz.writereg_w != '0) && (hz.writereg_w == rs_e_q)) begin
      fwd_a_c = FWD_WB;
    end
    fwd_b_c = FWD_RF;
    if (hz.regwrite_m && (hz.writereg_m != '0) && (hz.writereg_m == rt_e_q)) begin
      fwd_b_c = FWD_MEM;
    end else if (hz.regwrite_w && (hz.writereg_w != '0) && (hz.writereg_w == rt_e_q)) begin
      fwd_b_c = FWD_WB;
    end
  end

  // Saturating performance counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_f_c && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (hz.redirect_m && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_f   = stall_f_c;
  assign hz.stall_d   = stall_d_c;
  assign hz.flush_d   = flush_d_c;
  assign hz.flush_e   = flush_e_c;
  assign hz.flush_m   = flush_m_c;
  assign hz.fwd_a     = fwd_a_c;
  assign hz.fwd_b     = fwd_b_c;
  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: three instances share one stimulus
// (STALL_CYC=1/CNT_W=16, STALL_CYC=3/CNT_W=16, STALL_CYC=1/CNT_W=4).
module tb_pipe_hazard_ctrl;

  logic clk;
  logic clr;

  logic [4:0] rs_d, rt_d, writereg_e, writereg_m, writereg_w;
  logic       uses_rt_d, memtoreg_e, regwrite_m, regwrite_w, redirect_m;

  int checks;
  int errors;

  pipe_hazard_ctrl_if #(.CNT_W(16)) if1 ();
  pipe_hazard_ctrl_if #(.CNT_W(16)) if3 ();
  pipe_hazard_ctrl_if #(.CNT_W(4))  if4 ();

  pipe_hazard_ctrl #(.STALL_CYC(1), .CNT_W(16)) u_dut1 (.clk(clk), .clr(clr), .hz(if1));
  pipe_hazard_ctrl #(.STALL_CYC(3), .CNT_W(16)) u_dut3 (.clk(clk), .clr(clr), .hz(if3));
  pipe_hazard_ctrl #(.STALL_CYC(1), .CNT_W(4))  u_dut4 (.clk(clk), .clr(clr), .hz(if4));

  assign if1.rs_d = rs_d;             assign if3.rs_d = rs_d;             assign if4.rs_d = rs_d;
  assign if1.rt_d = rt_d;             assign if3.rt_d = rt_d;             assign if4.rt_d = rt_d;
  assign if1.uses_rt_d = uses_rt_d;   assign if3.uses_rt_d = uses_rt_d;   assign if4.uses_rt_d = uses_rt_d;
  assign if1.memtoreg_e = memtoreg_e; assign if3.memtoreg_e = memtoreg_e; assign if4.memtoreg_e = memtoreg_e;
  assign if1.writereg_e = writereg_e; assign if3.writereg_e = writereg_e; assign if4.writereg_e = writereg_e;
  assign if1.regwrite_m = regwrite_m; assign if3.regwrite_m = regwrite_m; assign if4.regwrite_m = regwrite_m;
  assign if1.writereg_m = writereg_m; assign if3.writereg_m = writereg_m; assign if4.writereg_m = writereg_m;
  assign if1.regwrite_w = regwrite_w; assign if3.regwrite_w = regwrite_w; assign if4.regwrite_w = regwrite_w;
  assign if1.writereg_w = writereg_w; assign if3.writereg_w = writereg_w; assign if4.writereg_w = writereg_w;
  assign if1.redirect_m = redirect_m; assign if3.redirect_m = redirect_m; assign if4.redirect_m = redirect_m;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs();
    rs_d = '0; rt_d = '0; uses_rt_d = 1'b0;
    memtoreg_e = 1'b0; writereg_e = '0;
    regwrite_m = 1'b0; writereg_m = '0;
    regwrite_w = 1'b0; writereg_w = '0;
    redirect_m = 1'b0;
  endtask

  task automatic do_reset();
    clr = 1'b0;
    zero_inputs();
    #1;
    step();
    clr = 1'b1;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr = 1'b0;
    zero_inputs();
    #2;
    // Reset values
    chk("rst_stall_f",   int'(if1.stall_f),   0);
    chk("rst_stall_d",   int'(if1.stall_d),   0);
    chk("rst_flush_d",   int'(if1.flush_d),   0);
    chk("rst_flush_e",   int'(if1.flush_e),   0);
    chk("rst_flush_m",   int'(if1.flush_m),   0);
    chk("rst_fwd_a",     int'(if1.fwd_a),     0);
    chk("rst_fwd_b",     int'(if1.fwd_b),     0);
    chk("rst_stall_cnt", int'(if1.stall_cnt), 0);
    chk("rst_flush_cnt", int'(if1.flush_cnt), 0);
    step();
    clr = 1'b1;
    #1;

    // 1: single-cycle load-use stall
    memtoreg_e = 1'b1; writereg_e = 5'd8; rs_d = 5'd8;
    #1;
    chk("t1_stall_f", int'(if1.stall_f), 1);
    chk("t1_stall_d", int'(if1.stall_d), 1);
    chk("t1_flush_e", int'(if1.flush_e), 1);
    chk("t1_flush_d", int'(if1.flush_d), 0);
    step();
    memtoreg_e = 1'b0; writereg_e = '0;
    #1;
    chk("t1_stall_off", int'(if1.stall_f),   0);
    chk("t1_stall_cnt", int'(if1.stall_cnt), 1);
    // rt hazard only counts when rt is a source
    memtoreg_e = 1'b1; writereg_e = 5'd9; rs_d = 5'd3; rt_d = 5'd9; uses_rt_d = 1'b0;
    #1;
    chk("t1_rt_unused", int'(if1.stall_f), 0);
    uses_rt_d = 1'b1;
    #1;
    chk("t1_rt_used", int'(if1.stall_f), 1);
    writereg_e = 5'd0; rs_d = 5'd0;
    #1;
    chk("t1_r0_load", int'(if1.stall_f), 0);

    // 2: three-cycle stall
    do_reset();
    memtoreg_e = 1'b1; writereg_e = 5'd8; rs_d = 5'd8;
    #1;
    chk("t2_c1_stall_f", int'(if3.stall_f), 1);
    step();
    memtoreg_e = 1'b0; writereg_e = '0;
    #1;
    chk("t2_c2_stall_f", int'(if3.stall_f), 1);
    chk("t2_c2_stall_d", int'(if3.stall_d), 1);
    chk("t2_c2_flush_e", int'(if3.flush_e), 1);
    step();
    chk("t2_c3_stall_f", int'(if3.stall_f), 1);
    step();
    chk("t2_run_stall_f", int'(if3.stall_f),   0);
    chk("t2_stall_cnt",   int'(if3.stall_cnt), 3);

    // 3: forwarding priority
    do_reset();
    rs_d = 5'd16; rt_d = 5'd16; uses_rt_d = 1'b1;
    step();
    regwrite_m = 1'b1; writereg_m = 5'd16; regwrite_w = 1'b1; writereg_w = 5'd16;
    #1;
    chk("t3_fwd_a_mem", int'(if1.fwd_a), 2);
    chk("t3_fwd_b_mem", int'(if1.fwd_b), 2);
    regwrite_m = 1'b0;
    #1;
    chk("t3_fwd_a_wb", int'(if1.fwd_a), 1);
    chk("t3_fwd_b_wb", int'(if1.fwd_b), 1);
    writereg_w = 5'd0;
    #1;
    chk("t3_fwd_a_none", int'(if1.fwd_a), 0);
    uses_rt_d = 1'b0; regwrite_m = 1'b1;
    step();
    chk("t3_fwd_a_mem2",  int'(if1.fwd_a), 2);
    chk("t3_fwd_b_nort",  int'(if1.fwd_b), 0);

    // 4: redirect beats load-use
    do_reset();
    rs_d = 5'd8; regwrite_m = 1'b1; writereg_m = 5'd8;
    step();
    chk("t4_pre_fwd_a", int'(if1.fwd_a), 2);
    memtoreg_e = 1'b1; writereg_e = 5'd8; redirect_m = 1'b1;
    #1;
    chk("t4_flush_d", int'(if1.flush_d), 1);
    chk("t4_flush_e", int'(if1.flush_e), 1);
    chk("t4_flush_m", int'(if1.flush_m), 1);
    chk("t4_stall_f", int'(if1.stall_f), 0);
    chk("t4_stall_d", int'(if1.stall_d), 0);
    step();
    redirect_m = 1'b0; memtoreg_e = 1'b0; writereg_e = '0;
    #1;
    chk("t4_flush_cnt", int'(if1.flush_cnt), 1);
    chk("t4_stall_cnt", int'(if1.stall_cnt), 0);
    chk("t4_rs_e_zero", int'(if1.fwd_a),     0);

    // 5: reset in the middle of a stall
    do_reset();
    memtoreg_e = 1'b1; writereg_e = 5'd8; rs_d = 5'd8;
    step();
    memtoreg_e = 1'b0; writereg_e = '0;
    #1;
    chk("t5_c2_stall_f", int'(if3.stall_f), 1);
    clr = 1'b0;
    #1;
    chk("t5_rst_stall_f",   int'(if3.stall_f),   0);
    chk("t5_rst_flush_e",   int'(if3.flush_e),   0);
    chk("t5_rst_stall_cnt", int'(if3.stall_cnt), 0);
    step();
    clr = 1'b1;
    #1;
    chk("t5_run_stall_f", int'(if3.stall_f), 0);
    step();
    chk("t5_run2_stall_f",  int'(if3.stall_f),   0);
    chk("t5_run_stall_cnt", int'(if3.stall_cnt), 0);

    // 6: flush counter saturation
    do_reset();
    redirect_m = 1'b1;
    repeat (14) step();
    chk("t6_cnt14", int'(if4.flush_cnt), 14);
    repeat (6) step();
    redirect_m = 1'b0;
    #1;
    chk("t6_sat",    int'(if4.flush_cnt), 15);
    chk("t6_wide20", int'(if1.flush_cnt), 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
